// File: rtl/fpall_rr_scheduler_if.sv
// Shared FP-unit request/response bundle: per-requester operation requests in, tagged results out.
// Latency: none, wires only.
// Backpressure: req_ready grants one requester at a time; rsp_ready stalls the result head.
package fpall_pkg;
    typedef enum logic [1:0] {
        FMT_FP32 = 2'd0,
        FMT_FP16 = 2'd1
    } fp_fmt_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAX = 2'd3
    } fp_op_e;
endpackage

interface fpall_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    fpall_pkg::fp_fmt_e req_fmt [N_REQ];
    fpall_pkg::fp_op_e  req_op  [N_REQ];
    logic [31:0]       req_x   [N_REQ];
    logic [31:0]       req_y   [N_REQ];
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_r;

    // Requesters and result consumer
    modport master (
        output req_valid, req_fmt, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_r
    );

    // Scheduler
    modport slave (
        input  req_valid, req_fmt, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_r
    );
endinterface

// File: rtl/fpall_rr_scheduler.sv
// Round-robin sharing of one pipelined FP unit between N_REQ requesters, results returned via a tagged FIFO.
// Latency: handshake edge E -> operands at E, result visible on rsp_* from edge E+LAT+1.
// Backpressure: issue only while in-flight + buffered results < FIFO_DEPTH, so no result is ever dropped.
module fpall_rr_scheduler #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = $clog2(N_REQ),
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpall_rr_scheduler_if.slave   bus,
    output fpall_pkg::fp_fmt_e    fpu_fmt,
    output fpall_pkg::fp_op_e     fpu_opcode,
    output logic [31:0]           fpu_x,
    output logic [31:0]           fpu_y,
    input  logic [31:0]           fpu_r
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + LAT + 2);
    localparam int ENT_W = ID_W + 32;

    logic [ID_W-1:0]                 ptr_q, ptr_d;
    fpall_pkg::fp_fmt_e              fpu_fmt_q, fpu_fmt_d;
    fpall_pkg::fp_op_e               fpu_op_q, fpu_op_d;
    logic [31:0]                     fpu_x_q, fpu_x_d;
    logic [31:0]                     fpu_y_q, fpu_y_d;
    logic [LAT:0]                    tag_vld_q, tag_vld_d;
    logic [LAT:0][ID_W-1:0]          tag_id_q, tag_id_d;
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [OCC_W-1:0] occ;
    logic            can_issue;
    logic            issue;
    logic            push;
    logic            pop;
    logic [ENT_W-1:0] head;

    // Pick the first valid requester after the last winner, wrapping around
    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_c   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(ptr_q) + k) % N_REQ;
            idx_c = ID_W'(idx);
            if (!gnt_vld && bus.req_valid[idx_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_c;
            end
        end
    end

    // Credit: every in-flight tag and every buffered result holds a FIFO slot; a same-cycle pop is not counted
    always_comb begin
        occ = OCC_W'(cnt_q);
        for (int i = 0; i <= LAT; i++) begin
            occ = occ + OCC_W'(tag_vld_q[i]);
        end
    end

    assign can_issue = (occ < OCC_W'(FIFO_DEPTH));
    assign issue     = gnt_vld && can_issue && rst_n;
    assign push      = tag_vld_q[LAT];
    assign pop       = bus.rsp_valid && bus.rsp_ready;

    // One-hot grant for the winning requester only
    always_comb begin
        bus.req_ready = '0;
        if (issue) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand registers and RR pointer update on issue; hold otherwise
    always_comb begin
        ptr_d     = ptr_q;
        fpu_fmt_d = fpu_fmt_q;
        fpu_op_d  = fpu_op_q;
        fpu_x_d   = fpu_x_q;
        fpu_y_d   = fpu_y_q;
        if (issue) begin
            ptr_d     = gnt_idx;
            fpu_fmt_d = bus.req_fmt[gnt_idx];
            fpu_op_d  = bus.req_op[gnt_idx];
            fpu_x_d   = bus.req_x[gnt_idx];
            fpu_y_d   = bus.req_y[gnt_idx];
        end
    end

    // Tag pipeline mirrors the unit latency; the last stage marks when fpu_r holds a result
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt_idx;
        for (int i = 1; i <= LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // Result FIFO: capture from the last tag stage, pop on consumer handshake
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {tag_id_q[LAT], fpu_r};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.rsp_valid = (cnt_q != '0);
    assign bus.rsp_id    = bus.rsp_valid ? head[ENT_W-1:32] : '0;
    assign bus.rsp_r     = bus.rsp_valid ? head[31:0] : '0;

    assign fpu_fmt    = fpu_fmt_q;
    assign fpu_opcode = fpu_op_q;
    assign fpu_x      = fpu_x_q;
    assign fpu_y      = fpu_y_q;

    // State registers; reset discards everything in flight or buffered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= ID_W'(N_REQ - 1);
            fpu_fmt_q <= fpall_pkg::FMT_FP32;
            fpu_op_q  <= fpall_pkg::OP_ADD;
            fpu_x_q   <= '0;
            fpu_y_q   <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            fpu_fmt_q <= fpu_fmt_d;
            fpu_op_q  <= fpu_op_d;
            fpu_x_q   <= fpu_x_d;
            fpu_y_q   <= fpu_y_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fpall_rr_scheduler.sv
// Directed bench for the shared-FPU round-robin scheduler with a 2-cycle behavioural FP unit.
// Latency: unit model registers its result twice after the operand registers load.
// Backpressure: rsp_ready driven directly by the stimulus sequence.
module tb_fpall_rr_scheduler;
    import fpall_pkg::*;

    localparam int N_REQ = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpall_rr_scheduler_if #(.N_REQ(N_REQ), .ID_W(2)) bus ();

    fp_fmt_e     fpu_fmt;
    fp_op_e      fpu_opcode;
    logic [31:0] fpu_x, fpu_y, fpu_r;

    fpall_rr_scheduler #(.N_REQ(N_REQ), .ID_W(2), .LAT(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fpu_fmt    (fpu_fmt),
        .fpu_opcode (fpu_opcode),
        .fpu_x      (fpu_x),
        .fpu_y      (fpu_y),
        .fpu_r      (fpu_r)
    );

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [33:0] exp_q [$];
    logic [1:0]  id_log [$];
    logic [31:0] r_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating bf16 adder for normal operands
    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p, q;
        int ep, ex, mp, mq, m, e;
        if (a[14:0] >= b[14:0]) begin p = a; q = b; end else begin p = b; q = a; end
        if (q[14:0] == 15'd0) return p;
        ep = int'(p[14:7]);
        ex = int'(q[14:7]);
        mp = int'({1'b1, p[6:0]}) << 8;
        mq = int'({1'b1, q[6:0]}) << 8;
        if (ep - ex > 16) mq = 0; else mq = mq >> (ep - ex);
        m = (p[15] == q[15]) ? mp + mq : mp - mq;
        if (m == 0) return 16'h0000;
        e = ep;
        while (m >= 65536) begin m = m >> 1; e++; end
        while (m < 32768) begin m = m << 1; e--; end
        return {p[15], e[7:0], m[14:8]};
    endfunction

    function automatic logic [31:0] fu(input fp_fmt_e f, input fp_op_e o, input logic [31:0] x, input logic [31:0] y);
        if (f == FMT_FP16 && o == OP_ADD) return {bf_add(x[31:16], y[31:16]), bf_add(x[15:0], y[15:0])};
        return x ^ y;
    endfunction

    // Behavioural shared unit: two register stages after the operand registers
    logic [31:0] u1, u2;
    always @(posedge clk) begin
        u1 <= fu(fpu_fmt, fpu_opcode, fpu_x, fpu_y);
        u2 <= u1;
    end
    assign fpu_r = u2;

    // Scoreboard: record accepts, compare every popped response in order
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[2'(i)] && bus.req_ready[2'(i)]) begin
                    acc_cnt++;
                    exp_q.push_back({2'(i), fu(bus.req_fmt[i], bus.req_op[i], bus.req_x[i], bus.req_y[i])});
                    chk("credit_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                id_log.push_back(bus.rsp_id);
                r_log.push_back(bus.rsp_r);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    chk("sb_id", 32'(bus.rsp_id), 32'(exp_q[0][33:32]));
                    chk("sb_r", bus.rsp_r, exp_q[0][31:0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_req(input int i, input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y);
        bus.req_fmt[i] = f;
        bus.req_op[i]  = OP_ADD;
        bus.req_x[i]   = x;
        bus.req_y[i]   = y;
    endtask

    initial begin
        int lat, a0, seen;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, FMT_FP32, 32'h0, 32'h0);

        // Reset state, with requests pending
        repeat (3) @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_fpu_x", fpu_x, 32'h0);
        chk("rst_fpu_y", fpu_y, 32'h0);
        chk("rst_fpu_fmt", 32'(fpu_fmt), 32'h0);
        chk("rst_fpu_op", 32'(fpu_opcode), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_r", bus.rsp_r, 32'h0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: bf16x2 1+1
        set_req(0, FMT_FP16, 32'h3F803F80, 32'h3F803F80);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        chk("single_fpu_x", fpu_x, 32'h3F803F80);
        chk("single_fpu_fmt", 32'(fpu_fmt), 32'(FMT_FP16));
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", 32'(lat), 32'd3);
        chk("single_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("single_rsp_r", bus.rsp_r, 32'h40004000);
        @(negedge clk);
        chk("single_popped", 32'(bus.rsp_valid), 32'd0);

        // Round-robin fairness from a freshly reset pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, FMT_FP32, 32'h1000_0001 * (i + 1), 32'h0F0F_0000 + i);
        id_log.delete();
        bus.req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
            @(negedge clk);
        end
        bus.req_valid = '0;
        drain("rr_drain");
        chk("rr_rsp_count", 32'(id_log.size()), 32'd6);
        for (int c = 0; c < 6; c++) begin
            if (c < id_log.size()) chk("rr_rsp_id", 32'(id_log[c]), 32'(c % 4));
        end

        // Backpressure: credit stops at FIFO_DEPTH accepts
        bus.rsp_ready = 1'b0;
        id_log.delete();
        a0 = acc_cnt;
        bus.req_valid = 4'b0010;
        repeat (16) @(negedge clk);
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd8);
        #1 chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
        bus.rsp_ready = 1'b1;
        #1 chk("bp_pop_not_credited", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_one_pop", 32'(id_log.size()), 32'd1);
        a0 = acc_cnt;
        #1 chk("bp_reaccept_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        chk("bp_one_accept", 32'(acc_cnt - a0), 32'd1);
        #1 chk("bp_ready_low_again", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain("bp_drain");
        chk("bp_rsp_count", 32'(id_log.size()), 32'd9);

        // Operand mix, back-to-back from requesters 2 and 3
        id_log.delete();
        r_log.delete();
        set_req(2, FMT_FP16, 32'h3FC03FC0, 32'hBFA0BFA0);
        set_req(3, FMT_FP16, 32'h3F803F80, 32'h3F803F80);
        bus.req_valid = 4'b1100;
        #1 chk("mix_grant2", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1 chk("mix_grant3", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_valid = '0;
        drain("mix_drain");
        chk("mix_count", 32'(r_log.size()), 32'd2);
        if (r_log.size() >= 2) begin
            chk("mix_r0", r_log[0], 32'h3E803E80);
            chk("mix_id0", 32'(id_log[0]), 32'd2);
            chk("mix_r1", r_log[1], 32'h40004000);
            chk("mix_id1", 32'(id_log[1]), 32'd3);
        end

        // Reset mid-flight: three ops issued, reset at the edge after the last one
        set_req(0, FMT_FP32, 32'hAAAA_0000, 32'h0000_5555);
        a0 = acc_cnt;
        bus.req_valid = 4'b0001;
        repeat (3) @(negedge clk);
        chk("mf_accepts", 32'(acc_cnt - a0), 32'd3);
        bus.req_valid = '0;
        id_log.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("mf_no_rsp", 32'(seen), 32'd0);
        chk("mf_no_pops", 32'(id_log.size()), 32'd0);
        bus.req_valid = 4'b0011;
        #1 chk("mf_lowest_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        drain("mf_drain");

        // Sparse requests: granted on the first valid cycle
        set_req(3, FMT_FP32, 32'h1234_5678, 32'h0F0F_0F0F);
        bus.req_valid = 4'b1000;
        #1 chk("sparse_req3", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        set_req(0, FMT_FP32, 32'hCAFE_0000, 32'h0000_BEEF);
        bus.req_valid = 4'b0001;
        #1 chk("sparse_req0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        drain("sparse_drain");
        @(negedge clk);
        chk("final_empty", 32'(bus.rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
